// File: rtl/id_ex_pkg.sv
// Shared widths, payload sizing and stage-state encoding for the ID->EX skid stage.
package id_ex_pkg;

   localparam int DEF_DATA_W  = 64;
   localparam int DEF_RADDR_W = 4;
   localparam int DEF_CNT_W   = 16;

   // Payload layout, MSB first: {wreg_en, wmem_en, r0data, r1data, wreg}
   function automatic int pay_w(input int data_w, input int raddr_w);
      return 2 + 2 * data_w + raddr_w;
   endfunction

   localparam int PAY_W = pay_w(DEF_DATA_W, DEF_RADDR_W);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } stage_state_e;

   // The skid entry is only ever valid while main is valid, so skid alone implies FULL.
   function automatic stage_state_e state_of(input logic main_vld, input logic skid_vld);
      if (skid_vld) begin
         return ST_FULL;
      end else if (main_vld) begin
         return ST_ONE;
      end
      return ST_EMPTY;
   endfunction

endpackage

// File: rtl/id_ex_skid_stage_pipe_entry_reg.sv
// One pipeline entry: payload register plus valid bit; clear beats load and leaves the payload intact.
module pipe_entry_reg #(
   parameter int W = id_ex_pkg::PAY_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic         clr_i,
   input  logic [W-1:0] d_i,
   output logic         vld_o,
   output logic [W-1:0] q_o
);

   logic         vld_q, vld_d;
   logic [W-1:0] pay_q, pay_d;

   always_comb begin
      vld_d = vld_q;
      pay_d = pay_q;
      if (clr_i) begin
         vld_d = 1'b0;
      end else if (load_i) begin
         vld_d = 1'b1;
         pay_d = d_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= 1'b0;
         pay_q <= '0;
      end else begin
         vld_q <= vld_d;
         pay_q <= pay_d;
      end
   end

   assign vld_o = vld_q;
   assign q_o   = pay_q;

endmodule

// File: rtl/id_ex_skid_stage.sv
// ID->EX pipeline register with valid/ready handshake, two-entry skid buffer,
// synchronous flush, bubble-masked write enables, hazard query and stall counter.
module id_ex_skid_stage
   import id_ex_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int RADDR_W = DEF_RADDR_W,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_wreg_en,
   input  logic               in_wmem_en,
   input  logic [DATA_W-1:0]  in_r0data,
   input  logic [DATA_W-1:0]  in_r1data,
   input  logic [RADDR_W-1:0] in_wreg,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_wreg_en,
   output logic               out_wmem_en,
   output logic [DATA_W-1:0]  out_r0data,
   output logic [DATA_W-1:0]  out_r1data,
   output logic [RADDR_W-1:0] out_wreg,
   input  logic [RADDR_W-1:0] q_raddr0,
   input  logic [RADDR_W-1:0] q_raddr1,
   output logic               hazard,
   output logic [CNT_W-1:0]   stall_cnt
);

   localparam int P_W = pay_w(DATA_W, RADDR_W);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W - 1){1'b0}}, 1'b1};

   logic [P_W-1:0] in_pay, main_pay, skid_pay, main_d;
   logic           main_vld, skid_vld;
   logic           main_load, main_clr, skid_load, skid_clr;
   logic           accept, drain;
   stage_state_e   state;
   logic           main_wreg_en;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   function automatic logic entry_hit(input logic vld, input logic wen,
                                      input logic [RADDR_W-1:0] wreg,
                                      input logic [RADDR_W-1:0] a0,
                                      input logic [RADDR_W-1:0] a1);
      return vld & wen & ((wreg == a0) | (wreg == a1));
   endfunction

   assign in_pay = {in_wreg_en, in_wmem_en, in_r0data, in_r1data, in_wreg};
   assign state  = state_of(main_vld, skid_vld);

   assign in_ready  = !skid_vld;
   assign out_valid = main_vld;
   assign accept    = in_valid & in_ready;
   assign drain     = out_valid & out_ready;

   // Flush wins over everything; a same-cycle drain is still taken by EX, only validity clears.
   always_comb begin
      main_load = 1'b0;
      main_clr  = 1'b0;
      skid_load = 1'b0;
      skid_clr  = 1'b0;
      main_d    = in_pay;
      if (flush) begin
         main_clr = 1'b1;
         skid_clr = 1'b1;
      end else begin
         case (state)
            ST_EMPTY: main_load = accept;
            ST_ONE: begin
               if (accept && drain) begin
                  main_load = 1'b1;
               end else if (accept) begin
                  skid_load = 1'b1;
               end else if (drain) begin
                  main_clr = 1'b1;
               end
            end
            ST_FULL: begin
               if (drain) begin
                  main_load = 1'b1;
                  main_d    = skid_pay;
                  skid_clr  = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   pipe_entry_reg #(.W(P_W)) u_main (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (main_load),
      .clr_i  (main_clr),
      .d_i    (main_d),
      .vld_o  (main_vld),
      .q_o    (main_pay)
   );

   pipe_entry_reg #(.W(P_W)) u_skid (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (skid_load),
      .clr_i  (skid_clr),
      .d_i    (in_pay),
      .vld_o  (skid_vld),
      .q_o    (skid_pay)
   );

   assign {main_wreg_en, out_wmem_en, out_r0data, out_r1data, out_wreg} =
      {main_pay[P_W-1], main_vld & main_pay[P_W-2], main_pay[P_W-3:0]};
   assign out_wreg_en = main_vld & main_wreg_en;

   assign hazard =
      entry_hit(main_vld, main_pay[P_W-1], main_pay[RADDR_W-1:0], q_raddr0, q_raddr1) |
      entry_hit(skid_vld, skid_pay[P_W-1], skid_pay[RADDR_W-1:0], q_raddr0, q_raddr1);

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid && !out_ready && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Scoreboard bench for id_ex_skid_stage: directed stimulus, monitor pops expected beats on each drain.
module tb_id_ex_skid_stage;

   localparam int DW = 64;
   localparam int AW = 4;
   localparam int CW = 4;
   localparam int PW = 2 + 2 * DW + AW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic          in_wreg_en;
   logic          in_wmem_en;
   logic [DW-1:0] in_r0data;
   logic [DW-1:0] in_r1data;
   logic [AW-1:0] in_wreg;
   logic          out_valid;
   logic          out_ready;
   logic          out_wreg_en;
   logic          out_wmem_en;
   logic [DW-1:0] out_r0data;
   logic [DW-1:0] out_r1data;
   logic [AW-1:0] out_wreg;
   logic [AW-1:0] q_raddr0;
   logic [AW-1:0] q_raddr1;
   logic          hazard;
   logic [CW-1:0] stall_cnt;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [PW-1:0] sb[$];

   id_ex_skid_stage #(.DATA_W(DW), .RADDR_W(AW), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_wreg_en  (in_wreg_en),
      .in_wmem_en  (in_wmem_en),
      .in_r0data   (in_r0data),
      .in_r1data   (in_r1data),
      .in_wreg     (in_wreg),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_wreg_en (out_wreg_en),
      .out_wmem_en (out_wmem_en),
      .out_r0data  (out_r0data),
      .out_r1data  (out_r1data),
      .out_wreg    (out_wreg),
      .q_raddr0    (q_raddr0),
      .q_raddr1    (q_raddr1),
      .hazard      (hazard),
      .stall_cnt   (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [AW-1:0] wreg, input logic we, input logic me,
                        input logic [DW-1:0] r0, input logic [DW-1:0] r1);
      in_valid   = 1'b1;
      in_wreg    = wreg;
      in_wreg_en = we;
      in_wmem_en = me;
      in_r0data  = r0;
      in_r1data  = r1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   // Handshakes are decided on the falling edge, half a cycle before the edge that commits them.
   task automatic monitor();
      logic [PW-1:0] act;
      logic [PW-1:0] exp;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            sb.delete();
         end else begin
            if (!out_valid) begin
               chk("bubble_wen", 64'({out_wreg_en, out_wmem_en}), 64'd0);
            end
            if (out_valid && out_ready) begin
               act = {out_wreg_en, out_wmem_en, out_r0data, out_r1data, out_wreg};
               n_cmp++;
               if (sb.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_beat: got wreg=%0d, required no beat", out_wreg);
               end else begin
                  exp = sb.pop_front();
                  if (act !== exp) begin
                     n_fail++;
                     $display("FAIL beat: got %h, required %h", act, exp);
                  end
               end
            end
            if (flush) begin
               sb.delete();
            end else if (in_valid && in_ready) begin
               sb.push_back({in_wreg_en, in_wmem_en, in_r0data, in_r1data, in_wreg});
            end
         end
      end
   endtask

   initial begin
      fork
         monitor();
      join_none

      rst_n      = 1'b0;
      flush      = 1'b0;
      out_ready  = 1'b0;
      q_raddr0   = '0;
      q_raddr1   = '0;
      in_wreg    = '0;
      in_wreg_en = 1'b0;
      in_wmem_en = 1'b0;
      in_r0data  = '0;
      in_r1data  = '0;
      idle();
      #3;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_hazard", 64'(hazard), 64'd0);
      chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      chk("rst_out_wreg", 64'(out_wreg), 64'd0);
      #9 rst_n = 1'b1;
      tick();

      // streaming
      out_ready = 1'b1;
      offer(4'd1, 1'b1, 1'b1, 64'h11, 64'hA001);
      chk("stream_in_ready0", 64'(in_ready), 64'd1);
      tick();
      chk("stream_latency_valid", 64'(out_valid), 64'd1);
      chk("stream_latency_wreg", 64'(out_wreg), 64'd1);
      offer(4'd2, 1'b1, 1'b0, 64'h22, 64'hA002);
      chk("stream_in_ready1", 64'(in_ready), 64'd1);
      tick();
      offer(4'd3, 1'b1, 1'b1, 64'h33, 64'hA003);
      chk("stream_in_ready2", 64'(in_ready), 64'd1);
      tick();
      offer(4'd4, 1'b1, 1'b0, 64'h44, 64'hA004);
      chk("stream_in_ready3", 64'(in_ready), 64'd1);
      tick();
      chk("stream_wreg4", 64'(out_wreg), 64'd4);
      idle();
      tick();
      chk("stream_empty", 64'(out_valid), 64'd0);

      // backpressure fill and drain
      out_ready = 1'b0;
      offer(4'd5, 1'b1, 1'b0, 64'h55, 64'hB005);
      tick();
      chk("bp_in_ready_one", 64'(in_ready), 64'd1);
      offer(4'd6, 1'b0, 1'b1, 64'h66, 64'hB006);
      tick();
      idle();
      chk("bp_in_ready_full", 64'(in_ready), 64'd0);
      chk("bp_stall1", 64'(stall_cnt), 64'd1);
      tick();
      chk("bp_stall2", 64'(stall_cnt), 64'd2);
      chk("bp_head", 64'(out_wreg), 64'd5);
      out_ready = 1'b1;
      tick();
      chk("bp_in_ready_back", 64'(in_ready), 64'd1);
      chk("bp_second", 64'(out_wreg), 64'd6);
      chk("bp_stall_hold", 64'(stall_cnt), 64'd2);
      tick();
      chk("bp_empty", 64'(out_valid), 64'd0);

      // flush while FULL with a beat offered
      out_ready = 1'b0;
      offer(4'd8, 1'b1, 1'b1, 64'h88, 64'hC008);
      tick();
      offer(4'd10, 1'b1, 1'b1, 64'hAA, 64'hC00A);
      tick();
      chk("fl_full", 64'(in_ready), 64'd0);
      flush = 1'b1;
      offer(4'd7, 1'b1, 1'b1, 64'h77, 64'hC007);
      tick();
      flush = 1'b0;
      idle();
      chk("fl_out_valid", 64'(out_valid), 64'd0);
      chk("fl_in_ready", 64'(in_ready), 64'd1);
      chk("fl_wmem", 64'(out_wmem_en), 64'd0);
      chk("fl_stall_kept", 64'(stall_cnt), 64'd4);
      out_ready = 1'b1;
      repeat (3) tick();
      chk("fl_no_beat7", 64'(out_valid), 64'd0);

      // hazard
      out_ready = 1'b0;
      q_raddr1  = 4'd12;
      offer(4'd3, 1'b1, 1'b0, 64'h300, 64'hD003);
      tick();
      offer(4'd9, 1'b0, 1'b0, 64'h900, 64'hD009);
      tick();
      idle();
      q_raddr0 = 4'd3;
      #1 chk("hz_main_q0", 64'(hazard), 64'd1);
      q_raddr0 = 4'd9;
      #1 chk("hz_skid_noen", 64'(hazard), 64'd0);
      q_raddr0 = 4'd12;
      q_raddr1 = 4'd3;
      #1 chk("hz_main_q1", 64'(hazard), 64'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      #1 chk("hz_after_drain", 64'(hazard), 64'd0);
      chk("hz_head9", 64'(out_wreg), 64'd9);
      out_ready = 1'b1;
      tick();
      q_raddr1 = 4'd9;
      #1 chk("hz_empty", 64'(hazard), 64'd0);

      // counter saturation
      out_ready = 1'b0;
      offer(4'd11, 1'b1, 1'b0, 64'hBB, 64'hE00B);
      tick();
      idle();
      repeat (20) tick();
      chk("sat_stall", 64'(stall_cnt), 64'd15);

      // asynchronous reset mid-stream with both entries valid
      offer(4'd12, 1'b1, 1'b1, 64'hCC, 64'hE00C);
      tick();
      idle();
      chk("pre_rst_full", 64'(in_ready), 64'd0);
      #1 rst_n = 1'b0;
      #1;
      chk("mrst_out_valid", 64'(out_valid), 64'd0);
      chk("mrst_wreg_en", 64'(out_wreg_en), 64'd0);
      chk("mrst_in_ready", 64'(in_ready), 64'd1);
      chk("mrst_stall", 64'(stall_cnt), 64'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (4) tick();
      chk("mrst_no_beat", 64'(out_valid), 64'd0);
      chk("mrst_stall_after", 64'(stall_cnt), 64'd0);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_skid_stage.md
Name: id_ex_skid_stage

Overview:
- Parametrised ID->EX pipeline register for the pipelined datapath. It replaces the plain enable-gated register with a valid/ready handshake and a two-entry skid buffer.
- Supports synchronous flush. Masks write enables on bubbles.
- Reports pending destination-register writes so the ID stage can detect RAW/load-use hazards.
- Sits between register-file read (ID) and the EX/MEM stage.

Parameters:
- DATA_W, 64, width of each register-file read operand.
- RADDR_W, 4, register address width.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous flush: kill all held and incoming beats
- in_valid  in  1  ID offers a beat
- in_ready  out  1  stage can accept a beat this cycle
- in_wreg_en  in  1  instruction writes the register file
- in_wmem_en  in  1  instruction writes data memory
- in_r0data  in  DATA_W  operand 0
- in_r1data  in  DATA_W  operand 1
- in_wreg  in  RADDR_W  destination register
- out_valid  out  1  beat presented to EX
- out_ready  in  1  EX consumes the beat this cycle
- out_wreg_en  out  1  held wreg_en ANDed with out_valid
- out_wmem_en  out  1  held wmem_en ANDed with out_valid
- out_r0data  out  DATA_W  operand 0
- out_r1data  out  DATA_W  operand 1
- out_wreg  out  RADDR_W  destination register
- q_raddr0  in  RADDR_W  hazard query address 0, from the instruction in ID
- q_raddr1  in  RADDR_W  hazard query address 1
- hazard  out  1  a valid held entry with wreg_en=1 has wreg equal to q_raddr0 or q_raddr1
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Storage: main entry (drives out_*) and skid entry. Each entry holds a valid bit plus the payload {wreg_en, wmem_en, r0data, r1data, wreg}.
- Reset (rst_n=0, asynchronous):
  - both valid bits 0, all payload 0, stall_cnt 0
  - outputs during reset: out_valid=0, out_* all 0, in_ready=1, hazard=0
- Handshake:
  - in_ready = !skid_valid; it depends only on stage state, never combinationally on out_ready
  - accept = in_valid & in_ready; drain = out_valid & out_ready
  - out_valid = main_valid
  - latency from accept to out_valid is 1 cycle
- States (derived from the valid bits):
  - EMPTY: main=0, skid=0
  - ONE: main=1, skid=0
  - FULL: main=1, skid=1
- Transitions when flush=0:
  - EMPTY + accept -> ONE, main<=in
  - EMPTY + no accept -> EMPTY
  - ONE + accept + drain -> ONE, main<=in
  - ONE + accept + no drain -> FULL, skid<=in
  - ONE + drain + no accept -> EMPTY
  - ONE + neither -> ONE, main held
  - FULL + drain -> ONE, main<=skid (no accept possible while FULL)
  - FULL + no drain -> FULL, both held
- Ordering: beats leave in acceptance order; none are lost or duplicated.
- Flush (highest priority, synchronous):
  - both valid bits <= 0; any beat offered in the same cycle is discarded
  - a drain in the same cycle still counts as consumed by EX
  - payload registers keep their values; only the valid bits clear
  - next cycle: in_ready=1, out_valid=0
- Bubble safety: out_wreg_en and out_wmem_en are forced to 0 whenever out_valid=0. The data and address outputs may show stale values.
- Hazard:
  - combinational OR over both entries of (valid & wreg_en & (wreg==q_raddr0 | wreg==q_raddr1))
  - no register-0 special case
- stall_cnt:
  - increments by 1 on each cycle with out_valid & !out_ready
  - saturates at all ones
  - flush does not clear it; only reset does

Decomposition:
- Shared package id_ex_pkg holds:
  - default widths DATA_W=64, RADDR_W=4
  - the derived payload width PAY_W = 2 + 2*DATA_W + RADDR_W
  - the state encoding EMPTY/ONE/FULL for debug visibility
- One natural sub-module: pipe_entry_reg. It is a PAY_W-wide payload register with a valid bit, load enable, synchronous valid-clear and async active-low reset. It is instantiated twice: main and skid.

Test Plan:
- Reset: pulse rst_n low mid-stream with both entries valid -> out_valid=0, out_wreg_en=0, in_ready=1, stall_cnt=0 immediately; no beat emerges after release.
- Streaming: out_ready=1, 4 back-to-back beats with wreg=1,2,3,4 and r0data=0x11..0x44 -> out_valid rises 1 cycle after the first accept and the beats appear in order on consecutive cycles; in_ready stays 1.
- Backpressure fill and drain:
  - out_ready=0, offer wreg=5 then wreg=6 -> in_ready=0 after the 2nd accept; stall_cnt advances 1 per cycle
  - raise out_ready -> wreg=5, then 6, emerge; in_ready returns to 1 one cycle after 5 drains
- Flush in FULL: flush=1 with in_valid=1 and wreg=7 offered -> next cycle out_valid=0, in_ready=1, out_wmem_en=0; beat 7 never appears.
- Hazard: main holds wreg=3 with wreg_en=1, skid holds wreg=9 with wreg_en=0:
  - q_raddr0=3 -> hazard=1
  - q_raddr0=9 -> hazard=0
  - q_raddr1=3 after main drains -> hazard=0
- Counter saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt stops at 15.
